matrix_operand_loader: RTL

//  Upstream feeder for the combinational matrix multiplier.
//  - Accepts matrix elements one word per beat on a valid/ready stream: all of A row-major, then all of B row-major.
//  - Packs them into the flat A/B operand vectors the multiplier consumes.
//  - Holds the operands stable with op_valid until the consumer acknowledges with op_ready, then reloads.

---
 rtl/matrix_mul_pkg.sv | 29 ++
 rtl/matrix_operand_loader_if.sv | 28 ++
 rtl/matrix_flat_packer.sv | 33 +++
 rtl/matrix_operand_loader.sv | 125 ++++++++++++
 4 files changed

// File: rtl/matrix_mul_pkg.sv
// Shared definitions for the matrix multiplier datapath: operand-loader FSM
// encodings and sizing helpers used by the loader, the multiplier and the
// downstream result unpacker.
package matrix_mul_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Number of elements in a rows x cols matrix.
  function automatic int unsigned elem_count(input int unsigned rows, input int unsigned cols);
    return rows * cols;
  endfunction

  // Width of a flat operand vector holding elems words.
  function automatic int unsigned flat_width(input int unsigned ws, input int unsigned elems);
    return ws * elems;
  endfunction

  // Slot counter width covering both matrices, never below one bit.
  function automatic int unsigned idx_width(input int unsigned na, input int unsigned nb);
    int unsigned m;
    m = (na > nb) ? na : nb;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Operand-loader bus: element input stream (in_*) and packed operand handoff
// (A_out/B_out with op_valid/op_ready).
//   master : the side feeding words and consuming operands
//   slave  : the loader
interface matrix_operand_loader_if #(
  parameter int unsigned word_size = 32,
  parameter int unsigned na        = 4,
  parameter int unsigned nb        = 2
);
  logic [word_size-1:0]    in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [na*word_size-1:0] A_out;
  logic [nb*word_size-1:0] B_out;
  logic                    op_valid;
  logic                    op_ready;

  modport master (
    output in_data, in_valid, in_last, op_ready,
    input  in_ready, A_out, B_out, op_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, op_ready,
    output in_ready, A_out, B_out, op_valid
  );
endinterface

// File: rtl/matrix_flat_packer.sv
// Flat register vector of elems words. A write stores din into slot idx, with
// slot 0 in the most significant word.
//   clk, rst : clock, synchronous active-high reset (clears the vector)
//   we       : write enable
//   idx      : slot to write
//   din      : word to store
//   flat     : packed slots, slot 0 in the MSBs
module matrix_flat_packer #(
  parameter int unsigned word_size = 32,
  parameter int unsigned elems     = 4,
  parameter int unsigned idx_w     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [idx_w-1:0]           idx,
  input  logic [word_size-1:0]       din,
  output logic [elems*word_size-1:0] flat
);

  always_ff @(posedge clk) begin
    if (rst) begin
      flat <= '0;
    end else if (we) begin
      for (int k = 0; k < elems; k++) begin
        if (idx == idx_w'(k)) begin
          flat[(elems-1-k)*word_size +: word_size] <= din;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Streams A (row-major) then B (row-major) one word per beat, packs them into
// flat operand vectors and holds them with op_valid until op_ready.
//   clk, rst : clock, synchronous active-high reset
//   clear    : synchronous abort back to LOAD_A; operand vectors are kept
//   bus      : input stream and operand handoff (slave side)
//   err      : sticky in_last protocol error
module matrix_operand_loader
  import matrix_mul_pkg::*;
#(
  parameter int unsigned word_size     = 32,
  parameter int unsigned Amatrixrownum = 2,
  parameter int unsigned Amatrixcolnum = 2,
  parameter int unsigned Bmatrixrownum = 2,
  parameter int unsigned Bmatrixcolnum = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  matrix_operand_loader_if.slave  bus,
  output logic                    err
);

  localparam int unsigned NA    = elem_count(Amatrixrownum, Amatrixcolnum);
  localparam int unsigned NB    = elem_count(Bmatrixrownum, Bmatrixcolnum);
  localparam int unsigned IdxW  = idx_width(NA, NB);
  localparam int unsigned AW    = flat_width(word_size, NA);
  localparam int unsigned BW    = flat_width(word_size, NB);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              err_q, err_d;
  logic              beat, last_beat, a_we, b_we;
  logic [AW-1:0]     a_flat;
  logic [BW-1:0]     b_flat;

  assign bus.in_ready = (state_q != HOLD) & ~rst;
  assign bus.op_valid = (state_q == HOLD);
  assign bus.A_out    = a_flat;
  assign bus.B_out    = b_flat;
  assign err          = err_q;

  assign beat      = bus.in_valid & bus.in_ready;
  assign last_beat = (state_q == LOAD_B) && (idx_q == IdxW'(NB - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    a_we    = 1'b0;
    b_we    = 1'b0;
    if (clear) begin
      // Abort wins over any simultaneous beat or handoff.
      state_d = LOAD_A;
      idx_d   = '0;
      err_d   = 1'b0;
    end else begin
      // in_last is only checked; the counter alone decides sequencing.
      if (beat && (bus.in_last != last_beat)) err_d = 1'b1;
      unique case (state_q)
        LOAD_A: if (beat) begin
          a_we = 1'b1;
          if (idx_q == IdxW'(NA - 1)) begin
            state_d = LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        LOAD_B: if (beat) begin
          b_we = 1'b1;
          if (last_beat) begin
            state_d = HOLD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        HOLD: if (bus.op_ready) state_d = LOAD_A;
        default: begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  matrix_flat_packer #(
    .word_size (word_size),
    .elems     (NA),
    .idx_w     (IdxW)
  ) u_pack_a (
    .clk  (clk),
    .rst  (rst),
    .we   (a_we),
    .idx  (idx_q),
    .din  (bus.in_data),
    .flat (a_flat)
  );

  matrix_flat_packer #(
    .word_size (word_size),
    .elems     (NB),
    .idx_w     (IdxW)
  ) u_pack_b (
    .clk  (clk),
    .rst  (rst),
    .we   (b_we),
    .idx  (idx_q),
    .din  (bus.in_data),
    .flat (b_flat)
  );

endmodule
